stopwatch_bcd: RTL and testbench

Decimal stopwatch core that consumes the 10 Hz one-cycle rollover pulse produced by the board's `counter_mod_k_ro` divider and counts elapsed time as M:SS.t in BCD. Start/stop, lap-hold and clear events come from synchronized, debounced switch or key levels. The BCD digits go to the seven-segment driver stage on the DE10-Lite top level.

---
 rtl/stopwatch_pkg.sv | 25 ++
 rtl/stopwatch_bcd_digit.sv | 34 +++
 rtl/stopwatch_bcd.sv | 199 +++++++++++++++++++
 tb/tb_stopwatch_bcd.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and digit moduli for the BCD stopwatch core.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAP  = 2'd2,
        STOP = 2'd3
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam int TENTHS_MOD   = 10;
    localparam int SEC_ONES_MOD = 10;
    localparam int SEC_TENS_MOD = 6;

    // Full M:SS.t value as one packed word, used for both live count and lap hold.
    typedef struct packed {
        bcd_t min;
        bcd_t sec_tens;
        bcd_t sec_ones;
        bcd_t tenths;
    } sw_count_t;

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One BCD counter digit with carry-out. MODULUS > 0 fixes the wrap value at
// MODULUS-1; MODULUS = 0 wraps at the run-time max input instead.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int MODULUS = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic inc,
    input  bcd_t max,
    output bcd_t q,
    output logic carry
);

    localparam bcd_t FIXED_MAX = (MODULUS > 0) ? bcd_t'(MODULUS - 1) : bcd_t'(0);

    bcd_t top;

    assign top   = (MODULUS > 0) ? FIXED_MAX : max;
    assign carry = inc & (q == top);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= (q == top) ? bcd_t'(0) : q + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_bcd.sv
// Decimal M:SS.t stopwatch core driven by a 10 Hz tick pulse.
// Optional lap-hold display is compiled in with STOPWATCH_LAP_EN.
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int MIN_LIMIT = 9
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic start_stop,
    input  logic lap,
    input  logic clear,
    output bcd_t d_tenths,
    output bcd_t d_sec_ones,
    output bcd_t d_sec_tens,
    output bcd_t d_min,
    output logic running,
    output logic lap_active,
    output logic overflow
);

    logic      ss_q;
    logic      clr_q;
    logic      ev_ss;
    logic      ev_clr;
    sw_state_t state;
    sw_state_t state_nxt;
    logic      clr_cnt;
    logic      count_en;
    logic      c_tenths;
    logic      c_sec_ones;
    logic      c_sec_tens;
    logic      c_min;
    sw_count_t live;
    sw_count_t disp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ss_q  <= 1'b0;
            clr_q <= 1'b0;
        end else begin
            ss_q  <= start_stop;
            clr_q <= clear;
        end
    end

    assign ev_ss  = start_stop & ~ss_q;
    assign ev_clr = clear & ~clr_q;

`ifdef STOPWATCH_LAP_EN
    logic      lap_q;
    logic      ev_lap;
    logic      capture;
    sw_count_t hold;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lap_q <= 1'b0;
        end else begin
            lap_q <= lap;
        end
    end

    assign ev_lap = lap & ~lap_q;
`else
    logic lap_unused;
    assign lap_unused = lap;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Each state only reacts to its legal events; clear outranks start_stop outranks lap.
    always_comb begin
        state_nxt = state;
        clr_cnt   = 1'b0;
`ifdef STOPWATCH_LAP_EN
        capture   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (ev_ss) state_nxt = RUN;
            end
            RUN: begin
                if (ev_ss) begin
                    state_nxt = STOP;
                end
`ifdef STOPWATCH_LAP_EN
                else if (ev_lap) begin
                    state_nxt = LAP;
                    capture   = 1'b1;
                end
`endif
            end
`ifdef STOPWATCH_LAP_EN
            LAP: begin
                if (ev_ss) begin
                    state_nxt = STOP;
                end else if (ev_lap) begin
                    state_nxt = RUN;
                end
            end
`endif
            STOP: begin
                if (ev_clr) begin
                    state_nxt = IDLE;
                    clr_cnt   = 1'b1;
                end else if (ev_ss) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Count enable looks at the current state, so an event in the same cycle
    // as a tick never changes whether that tick is counted.
    assign count_en = tick & ((state == RUN) || (state == LAP));

    bcd_digit #(.MODULUS(TENTHS_MOD)) u_tenths (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr_cnt),
        .inc     (count_en),
        .max     (bcd_t'(TENTHS_MOD - 1)),
        .q       (live.tenths),
        .carry   (c_tenths)
    );

    bcd_digit #(.MODULUS(SEC_ONES_MOD)) u_sec_ones (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr_cnt),
        .inc     (c_tenths),
        .max     (bcd_t'(SEC_ONES_MOD - 1)),
        .q       (live.sec_ones),
        .carry   (c_sec_ones)
    );

    bcd_digit #(.MODULUS(SEC_TENS_MOD)) u_sec_tens (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr_cnt),
        .inc     (c_sec_ones),
        .max     (bcd_t'(SEC_TENS_MOD - 1)),
        .q       (live.sec_tens),
        .carry   (c_sec_tens)
    );

    // Minutes wrap at the parameterised limit, supplied at run time.
    bcd_digit #(.MODULUS(0)) u_min (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr_cnt),
        .inc     (c_sec_tens),
        .max     (bcd_t'(MIN_LIMIT)),
        .q       (live.min),
        .carry   (c_min)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (clr_cnt) begin
            overflow <= 1'b0;
        end else if (c_min) begin
            overflow <= 1'b1;
        end
    end

`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold <= '0;
        end else if (capture) begin
            hold <= live;
        end
    end

    assign disp       = (state == LAP) ? hold : live;
    assign lap_active = (state == LAP);
`else
    assign disp       = live;
    assign lap_active = 1'b0;
`endif

    assign running    = (state == RUN) || (state == LAP);
    assign d_tenths   = disp.tenths;
    assign d_sec_ones = disp.sec_ones;
    assign d_sec_tens = disp.sec_tens;
    assign d_min      = disp.min;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Self-checking bench for stopwatch_bcd against an elapsed-tenths reference model.
// Lap-hold checks follow STOPWATCH_LAP_EN.
module tb_stopwatch_bcd;

    localparam int MIN_LIMIT = 9;
    localparam int WRAP      = (MIN_LIMIT + 1) * 600;
    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_LAP     = 2;
    localparam int M_STOP    = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic       start_stop = 1'b0;
    logic       lap = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] d_tenths;
    logic [3:0] d_sec_ones;
    logic [3:0] d_sec_tens;
    logic [3:0] d_min;
    logic       running;
    logic       lap_active;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    // Reference model: elapsed time as a plain count of tenths.
    int m_st    = M_IDLE;
    int m_count = 0;
    int m_hold  = 0;
    bit m_ovf   = 1'b0;
    bit m_ss_q  = 1'b0;
    bit m_lap_q = 1'b0;
    bit m_clr_q = 1'b0;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    stopwatch_bcd #(.MIN_LIMIT(MIN_LIMIT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .d_tenths   (d_tenths),
        .d_sec_ones (d_sec_ones),
        .d_sec_tens (d_sec_tens),
        .d_min      (d_min),
        .running    (running),
        .lap_active (lap_active),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st    = M_IDLE;
        m_count = 0;
        m_hold  = 0;
        m_ovf   = 1'b0;
        m_ss_q  = 1'b0;
        m_lap_q = 1'b0;
        m_clr_q = 1'b0;
    endtask

    task automatic model_step();
        bit e_ss;
        bit e_lap;
        bit e_clr;
        bit counting;
        int ns;
        e_ss     = start_stop & ~m_ss_q;
        e_lap    = lap & ~m_lap_q & LAP_EN;
        e_clr    = clear & ~m_clr_q;
        counting = tick && (m_st == M_RUN || m_st == M_LAP);
        ns       = m_st;
        if (m_st == M_IDLE && e_ss) ns = M_RUN;
        if (m_st == M_RUN) begin
            if (e_ss) ns = M_STOP;
            else if (e_lap) begin
                ns     = M_LAP;
                m_hold = m_count;
            end
        end
        if (m_st == M_LAP) begin
            if (e_ss) ns = M_STOP;
            else if (e_lap) ns = M_RUN;
        end
        if (counting) begin
            m_count = m_count + 1;
            if (m_count == WRAP) begin
                m_count = 0;
                m_ovf   = 1'b1;
            end
        end
        if (m_st == M_STOP) begin
            if (e_clr) begin
                ns      = M_IDLE;
                m_count = 0;
                m_ovf   = 1'b0;
            end else if (e_ss) ns = M_RUN;
        end
        m_st    = ns;
        m_ss_q  = start_stop;
        m_lap_q = lap;
        m_clr_q = clear;
    endtask

    task automatic cyc(input bit t, input bit ss, input bit lp, input bit cl);
        tick       = t;
        start_stop = ss;
        lap        = lp;
        clear      = cl;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model(input string tag);
        int v;
        v = (m_st == M_LAP) ? m_hold : m_count;
        chk({tag, ".min"},      {4'b0, d_min},      8'(v / 600));
        chk({tag, ".sec_tens"}, {4'b0, d_sec_tens}, 8'((v % 600) / 100));
        chk({tag, ".sec_ones"}, {4'b0, d_sec_ones}, 8'(((v % 600) / 10) % 10));
        chk({tag, ".tenths"},   {4'b0, d_tenths},   8'(v % 10));
        chk({tag, ".running"},  {7'b0, running},    8'(m_st == M_RUN || m_st == M_LAP));
        chk({tag, ".lap"},      {7'b0, lap_active}, 8'(m_st == M_LAP));
        chk({tag, ".ovf"},      {7'b0, overflow},   8'(m_ovf));
    endtask

    task automatic chk_disp(input string tag, input int m, input int st, input int so, input int t);
        chk({tag, ".min"},      {4'b0, d_min},      8'(m));
        chk({tag, ".sec_tens"}, {4'b0, d_sec_tens}, 8'(st));
        chk({tag, ".sec_ones"}, {4'b0, d_sec_ones}, 8'(so));
        chk({tag, ".tenths"},   {4'b0, d_tenths},   8'(t));
    endtask

    initial begin
        bit ss_l;
        bit lp_l;
        bit cl_l;
        int n;

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_disp("rst", 0, 0, 0, 0);
        chk("rst.running", {7'b0, running}, 8'd0);
        chk("rst.ovf", {7'b0, overflow}, 8'd0);
        reset_n = 1'b1;

        // Start and 25 ticks -> 0:02.5
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 25; i++) cyc(1, 0, 0, 0);
        chk_disp("t25", 0, 0, 2, 5);
        chk("t25.running", {7'b0, running}, 8'd1);
        chk("t25.ovf", {7'b0, overflow}, 8'd0);
        check_model("t25");

        // Up to 0:59.9, then the minute carry
        for (int i = 0; i < 574; i++) cyc(1, 0, 0, 0);
        chk_disp("t599", 0, 5, 9, 9);
        cyc(1, 0, 0, 0);
        chk_disp("t600", 1, 0, 0, 0);

        // Stop with coincident tick in RUN: tick counted
        cyc(1, 1, 0, 0);
        chk_disp("stop_tick", 1, 0, 0, 1);
        chk("stop_tick.running", {7'b0, running}, 8'd0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
        check_model("stopped");

        // Start with coincident tick in STOP: tick not counted
        cyc(1, 1, 0, 0);
        chk_disp("start_tick", 1, 0, 0, 1);
        chk("start_tick.running", {7'b0, running}, 8'd1);
        cyc(0, 0, 0, 0);

        // Clear in RUN is ignored
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 0);
        chk_disp("clr_run", 1, 0, 0, 3);
        check_model("clr_run");

        // Run to full wrap
        n = WRAP - m_count - 1;
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
        chk_disp("pre_wrap", MIN_LIMIT, 5, 9, 9);
        chk("pre_wrap.ovf", {7'b0, overflow}, 8'd0);
        cyc(1, 0, 0, 0);
        chk_disp("wrap", 0, 0, 0, 0);
        chk("wrap.ovf", {7'b0, overflow}, 8'd1);
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0);
        chk("wrap_hold.ovf", {7'b0, overflow}, 8'd1);

        // Stop then clear -> IDLE, zeros, overflow cleared
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        chk_disp("clear", 0, 0, 0, 0);
        chk("clear.ovf", {7'b0, overflow}, 8'd0);
        chk("clear.running", {7'b0, running}, 8'd0);
        cyc(0, 0, 0, 0);

        // Clear and start_stop together in STOP: clear wins
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 37; i++) cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk_disp("stop37", 0, 0, 3, 7);
        cyc(0, 1, 0, 1);
        chk_disp("clr_ss", 0, 0, 0, 0);
        chk("clr_ss.running", {7'b0, running}, 8'd0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        check_model("idle_ticks");

        // Lap hold and release
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 30; i++) cyc(1, 0, 0, 0);
`ifdef STOPWATCH_LAP_EN
        chk_disp("lap_hold", 0, 0, 1, 2);
        chk("lap_hold.active", {7'b0, lap_active}, 8'd1);
`else
        chk_disp("lap_off", 0, 0, 4, 2);
        chk("lap_off.active", {7'b0, lap_active}, 8'd0);
`endif
        cyc(0, 0, 1, 0);
        chk_disp("lap_rel", 0, 0, 4, 2);
        chk("lap_rel.active", {7'b0, lap_active}, 8'd0);
        check_model("lap_rel");
        cyc(0, 0, 0, 0);

        // Lap capture with coincident tick takes the pre-increment value
        cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 0);
        check_model("lap_tick");
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        check_model("lap_clean");

        // Randomised levels and ticks against the model
        ss_l = 1'b0;
        lp_l = 1'b0;
        cl_l = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) ss_l = ~ss_l;
            if ($urandom_range(0, 7) == 0) lp_l = ~lp_l;
            if ($urandom_range(0, 11) == 0) cl_l = ~cl_l;
            cyc(1'($urandom_range(0, 1)), ss_l, lp_l, cl_l);
            check_model("rand");
        end
        cyc(0, 0, 0, 0);

        // Asynchronous reset between clock edges while running
        if (m_st != M_RUN) begin
            if (m_st == M_LAP) cyc(0, 0, 1, 0);
            else cyc(0, 1, 0, 0);
            cyc(0, 0, 0, 0);
        end
        for (int i = 0; i < 23; i++) cyc(1, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_disp("async_rst", 0, 0, 0, 0);
        chk("async_rst.running", {7'b0, running}, 8'd0);
        chk("async_rst.lap", {7'b0, lap_active}, 8'd0);
        chk("async_rst.ovf", {7'b0, overflow}, 8'd0);
        model_reset();
        tick = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
        chk_disp("post_rst", 0, 0, 0, 0);
        chk("post_rst.running", {7'b0, running}, 8'd0);

        // start_stop already high at reset release produces an event
        reset_n    = 1'b0;
        start_stop = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("high_rel.running", {7'b0, running}, 8'd1);
        check_model("high_rel");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
